// File: rtl/add_issue_ctrl.sv
// Issue stage ahead of the execute adder: buffers requests, issues one at a time, holds results for writeback.
// Optional WAIT watchdog with sticky err_timeout_o, enabled by defining ADD_ISSUE_WATCHDOG_EN.
module add_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_op_i,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             exe_start_o,
    output logic             exe_op_o,
    output logic [31:0]      exe_a_o,
    output logic [31:0]      exe_b_o,
    input  logic             exe_valid_i,
    input  logic [31:0]      exe_result_i,
`ifdef ADD_ISSUE_WATCHDOG_EN
    output logic             err_timeout_o,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [31:0]      out_result_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    typedef struct packed {
        logic             op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              out_valid_q;
    logic [31:0]       out_result_q;
    logic [TAG_W-1:0]  out_tag_q;
    entry_t            head;
    logic              full, empty, push, pop, capture, slot_free, timeout;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready_o = !full && !rst_i;
    assign push       = in_valid_i && in_ready_o;
    assign head       = mem_q[rd_ptr_q];
    assign slot_free  = !out_valid_q || out_ready_i;
    assign capture    = (state_q == S_WAIT) && exe_valid_i;
    // Head leaves only when its result is captured (or abandoned by the watchdog).
    assign pop        = capture || timeout;

    assign exe_start_o  = (state_q == S_ISSUE);
    assign exe_op_o     = head.op;
    assign exe_a_o      = head.a;
    assign exe_b_o      = head.b;
    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_tag_o    = out_tag_q;

`ifdef ADD_ISSUE_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_cnt_q;
    logic          err_q;

    assign timeout       = (state_q == S_WAIT) && !exe_valid_i && (wd_cnt_q == WW'(TIMEOUT - 1));
    assign err_timeout_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)     wd_cnt_q <= '0;
            else if (state_q == S_WAIT) wd_cnt_q <= wd_cnt_q + WW'(1);
            if (timeout)                err_q    <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= '{op: in_op_i, a: in_a_i, b: in_b_i, tag: in_tag_i};
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty && slot_free) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            state_q <= state_d;
            if (capture) begin
                out_valid_q  <= 1'b1;
                out_result_q <= exe_result_i;
                out_tag_q    <= head.tag;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_add_issue_ctrl.sv
// Directed bench for add_issue_ctrl; the adder is played by the stimulus thread with hand-computed results.
module tb_add_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_op;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        exe_start, exe_op;
    logic [31:0] exe_a, exe_b;
    logic        exe_valid;
    logic [31:0] exe_result;
    logic        out_valid, out_ready;
    logic [3:0]  out_tag;
    logic [31:0] out_result;
`ifdef ADD_ISSUE_WATCHDOG_EN
    logic        err_timeout;
`endif

    int checks = 0;
    int errors = 0;
    int n_start = 0;

    add_issue_ctrl #(.DEPTH(4), .TAG_W(4), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
        .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
        .exe_start_o(exe_start), .exe_op_o(exe_op), .exe_a_o(exe_a), .exe_b_o(exe_b),
        .exe_valid_i(exe_valid), .exe_result_i(exe_result),
`ifdef ADD_ISSUE_WATCHDOG_EN
        .err_timeout_o(err_timeout),
`endif
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_tag_o(out_tag), .out_result_o(out_result)
    );

    always #5 clk = ~clk;

    // Counts issue pulses; sampled at the edge so it sees the cycle just ending.
    always @(posedge clk) if (exe_start) n_start++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        chk("push_rdy", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20 && !exe_start; i++) @(negedge clk);
        chk("start_seen", exe_start, 1);
    endtask

    // Called at the negedge of the ISSUE cycle; done arrives lat cycles later.
    task automatic finish_op(input int lat, input logic [31:0] res);
        repeat (lat) @(negedge clk);
        exe_valid = 1'b1; exe_result = res;
        @(negedge clk);
        exe_valid = 1'b0; exe_result = '0;
    endtask

    initial begin
        int s;
        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        exe_valid = 1'b0; exe_result = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_exe_start", exe_start, 0);
        chk("rst_in_ready_rel", in_ready, 1);
`ifdef ADD_ISSUE_WATCHDOG_EN
        chk("rst_err", err_timeout, 0);
`endif

        // Single add: decision cycle, then exactly one start pulse.
        s = n_start;
        push(1'b0, 32'd5, 32'd7, 4'd3);
        chk("single_idle_cycle", exe_start, 0);
        @(negedge clk);
        chk("single_start", exe_start, 1);
        chk("single_op", exe_op, 0);
        chk("single_a", exe_a, 32'd5);
        chk("single_b", exe_b, 32'd7);
        finish_op(2, 32'd12);
        chk("single_ov", out_valid, 1);
        chk("single_res", out_result, 32'd12);
        chk("single_tag", out_tag, 3);
        repeat (4) @(negedge clk);
        chk("single_npulse", n_start - s, 1);
        chk("single_ov_clr", out_valid, 0);

        // Output stall: queued request must not issue while the slot is held.
        out_ready = 1'b0;
        push(1'b0, 32'd5, 32'd7, 4'd1);
        wait_start();
        finish_op(2, 32'd12);
        push(1'b1, 32'd9, 32'd4, 4'd2);
        s = n_start;
        repeat (6) @(negedge clk);
        chk("stall_nostart", n_start - s, 0);
        chk("stall_ov", out_valid, 1);
        chk("stall_res", out_result, 32'd12);
        chk("stall_tag", out_tag, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_ov_clr", out_valid, 0);
        wait_start();
        chk("stall2_op", exe_op, 1);
        finish_op(2, 32'd5);
        chk("stall2_res", out_result, 32'd5);
        chk("stall2_tag", out_tag, 2);
        repeat (2) @(negedge clk);

        // Stable operands across a 5-cycle adder.
        push(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7);
        wait_start();
        for (int i = 0; i <= 5; i++) begin
            chk("stable_a", exe_a, 32'hFFFF_FFFF);
            chk("stable_b", exe_b, 32'd1);
            chk("stable_op", exe_op, 1);
            if (i < 5) @(negedge clk);
        end
        exe_valid = 1'b1; exe_result = 32'hFFFF_FFFE;
        @(negedge clk);
        exe_valid = 1'b0; exe_result = '0;
        chk("stable_res", out_result, 32'hFFFF_FFFE);
        chk("stable_tag", out_tag, 7);
        repeat (2) @(negedge clk);

        // Back-to-back fill: four pushes, fifth refused, results in order.
        in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            in_op = 1'b0; in_a = 32'(t); in_b = 32'd100; in_tag = 4'(t);
            @(negedge clk);
        end
        chk("fill_full", in_ready, 0);
        in_a = 32'd55; in_tag = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fill_still_full", in_ready, 0);
        exe_valid = 1'b1; exe_result = 32'd100;
        @(negedge clk);
        exe_valid = 1'b0;
        chk("fill_tag0", out_tag, 0);
        chk("fill_res0", out_result, 32'd100);
        chk("fill_rdy_after_pop", in_ready, 1);
        for (int t = 1; t < 4; t++) begin
            wait_start();
            chk("fill_a", exe_a, 32'(t));
            finish_op(2, 32'(100 + t));
            chk("fill_tag", out_tag, 32'(t));
            chk("fill_res", out_result, 32'(100 + t));
        end
        s = n_start;
        repeat (5) @(negedge clk);
        chk("fill_fifth_dropped", n_start - s, 0);

        // Reset in WAIT followed by a stray done strobe.
        push(1'b0, 32'd1, 32'd2, 4'd4);
        wait_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exe_valid = 1'b1; exe_result = 32'd3;
        @(negedge clk);
        exe_valid = 1'b0; exe_result = '0;
        chk("rstw_ov", out_valid, 0);
        chk("rstw_rdy", in_ready, 1);
        s = n_start;
        repeat (4) @(negedge clk);
        chk("rstw_empty", n_start - s, 0);
        chk("rstw_ov2", out_valid, 0);

`ifdef ADD_ISSUE_WATCHDOG_EN
        push(1'b0, 32'd1, 32'd1, 4'd6);
        wait_start();
        repeat (15) @(negedge clk);
        chk("wd_err_early", err_timeout, 0);
        @(negedge clk);
        chk("wd_err", err_timeout, 1);
        chk("wd_ov", out_valid, 0);
        push(1'b0, 32'd2, 32'd3, 4'd8);
        wait_start();
        finish_op(2, 32'd5);
        chk("wd_next_res", out_result, 32'd5);
        chk("wd_next_tag", out_tag, 8);
        chk("wd_sticky", err_timeout, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
